// File: rtl/dataplane_core.sv
// dataplane_core
//    Programmable-logic dataplane block. An AXI4-Lite slave exposes control,
//    scratch and status registers. An AXI4-Stream receive port counts packets
//    and bytes and captures the last accepted data beat.
//
//    Ports
//       clk, rst_n              : system clock, asynchronous active-low reset
//       AW*/W*/B*               : AXI4-Lite write channels (addr bits [7:0] decoded)
//       AR*/R*                  : AXI4-Lite read channels  (addr bits [7:0] decoded)
//       tvalid/tdata/tkeep/tlast: AXI4-Stream receive beat
//       tready                  : stream ready, equal to CTRL.RX_EN after reset
//
//    Register map (32-bit, word aligned)
//       0x00 CTRL  0x04 SCRATCH  0x08 RX_PKT_CNT  0x0C RX_BYTE_CNT
//       0x10 LAST_LO  0x14 LAST_HI  0x18 VERSION
module dataplane_core #(
   parameter int DATA_WIDTH = 64
) (
   input  logic                      clk,
   input  logic                      rst_n,
   // write address
   input  logic [31:0]               AWADDR,
   input  logic [2:0]                AWPROT,
   input  logic                      AWVALID,
   output logic                      AWREADY,
   // write data
   input  logic [31:0]               WDATA,
   input  logic [3:0]                WSTRB,
   input  logic                      WVALID,
   output logic                      WREADY,
   // write response
   output logic                      BVALID,
   input  logic                      BREADY,
   output logic [1:0]                BRESP,
   // read address
   input  logic [31:0]               ARADDR,
   input  logic [2:0]                ARPROT,
   input  logic                      ARVALID,
   output logic                      ARREADY,
   // read data
   output logic                      RVALID,
   input  logic                      RREADY,
   output logic [31:0]               RDATA,
   output logic [1:0]                RRESP,
   // stream receive
   input  logic                      tvalid,
   input  logic [DATA_WIDTH-1:0]     tdata,
   input  logic [DATA_WIDTH/8-1:0]   tkeep,
   input  logic                      tlast,
   output logic                      tready
);

   localparam int unsigned KEEP_W = DATA_WIDTH / 8;

   localparam logic [7:0] ADDR_CTRL    = 8'h00;
   localparam logic [7:0] ADDR_SCRATCH = 8'h04;
   localparam logic [7:0] ADDR_PKT     = 8'h08;
   localparam logic [7:0] ADDR_BYTE    = 8'h0C;
   localparam logic [7:0] ADDR_LAST_LO = 8'h10;
   localparam logic [7:0] ADDR_LAST_HI = 8'h14;
   localparam logic [7:0] ADDR_VERSION = 8'h18;

   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;
   localparam logic [31:0] VERSION_VAL = 32'h0001_0000;

   // ready outputs are held low until the first clock after reset release
   logic        r_rdy_en;

   // control / status registers
   logic        r_rx_en;
   logic [31:0] r_scratch;
   logic [31:0] r_pkt_cnt;
   logic [31:0] r_byte_cnt;
   logic [31:0] r_last_lo;
   logic [31:0] r_last_hi;

   // write buffers and response
   logic        r_aw_full;
   logic [7:0]  r_aw_addr;
   logic        r_w_full;
   logic [31:0] r_w_data;
   logic [3:0]  r_w_strb;
   logic        r_bvalid;
   logic [1:0]  r_bresp;

   // read response
   logic        r_rvalid;
   logic [31:0] r_rdata;
   logic [1:0]  r_rresp;

   logic        w_wr_go;
   logic        w_wr_ok;
   logic [31:0] w_wmask;
   logic        w_cnt_clr;
   logic        w_beat;
   logic [31:0] w_keep_cnt;
   logic [31:0] w_tdata_hi;
   logic [31:0] w_rd_data;
   logic        w_rd_ok;
   logic        w_unused;

   assign w_unused = ^{AWADDR[31:8], ARADDR[31:8], AWPROT, ARPROT, tdata};

   assign AWREADY = r_rdy_en && !r_aw_full && !r_bvalid;
   assign WREADY  = r_rdy_en && !r_w_full  && !r_bvalid;
   assign ARREADY = r_rdy_en && !r_rvalid;
   assign BVALID  = r_bvalid;
   assign BRESP   = r_bresp;
   assign RVALID  = r_rvalid;
   assign RDATA   = r_rdata;
   assign RRESP   = r_rresp;
   assign tready  = r_rdy_en && r_rx_en;

   assign w_beat  = tvalid && tready;

   generate
      if (DATA_WIDTH >= 64) begin : g_hi
         assign w_tdata_hi = tdata[63:32];
      end else begin : g_no_hi
         assign w_tdata_hi = '0;
      end
   endgenerate

   // number of valid bytes in the beat; sparse masks are simply counted
   always_comb begin
      w_keep_cnt = '0;
      for (int unsigned i = 0; i < KEEP_W; i++) begin
         w_keep_cnt = w_keep_cnt + 32'(tkeep[i]);
      end
   end

   // the buffered write commits once, on the edge where both halves are held
   assign w_wr_go   = r_aw_full && r_w_full && !r_bvalid;
   assign w_wmask   = {{8{r_w_strb[3]}}, {8{r_w_strb[2]}}, {8{r_w_strb[1]}}, {8{r_w_strb[0]}}};
   assign w_cnt_clr = w_wr_go && (r_aw_addr == ADDR_CTRL) && r_w_strb[0] && r_w_data[1];

   always_comb begin
      w_wr_ok = 1'b1;
      case (r_aw_addr)
         ADDR_CTRL, ADDR_SCRATCH, ADDR_PKT, ADDR_BYTE,
         ADDR_LAST_LO, ADDR_LAST_HI, ADDR_VERSION: w_wr_ok = 1'b1;
         default:                                  w_wr_ok = 1'b0;
      endcase
   end

   always_comb begin
      w_rd_data = '0;
      w_rd_ok   = 1'b1;
      case (ARADDR[7:0])
         ADDR_CTRL:    w_rd_data = {31'b0, r_rx_en};
         ADDR_SCRATCH: w_rd_data = r_scratch;
         ADDR_PKT:     w_rd_data = r_pkt_cnt;
         ADDR_BYTE:    w_rd_data = r_byte_cnt;
         ADDR_LAST_LO: w_rd_data = r_last_lo;
         ADDR_LAST_HI: w_rd_data = r_last_hi;
         ADDR_VERSION: w_rd_data = VERSION_VAL;
         default:      w_rd_ok   = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdy_en <= 1'b0;
      end else begin
         r_rdy_en <= 1'b1;
      end
   end

   // write channel: independent AW/W buffers, response, and buffer release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_aw_full <= 1'b0;
         r_aw_addr <= '0;
         r_w_full  <= 1'b0;
         r_w_data  <= '0;
         r_w_strb  <= '0;
         r_bvalid  <= 1'b0;
         r_bresp   <= RESP_OKAY;
      end else begin
         if (AWVALID && AWREADY) begin
            r_aw_full <= 1'b1;
            r_aw_addr <= AWADDR[7:0];
         end
         if (WVALID && WREADY) begin
            r_w_full <= 1'b1;
            r_w_data <= WDATA;
            r_w_strb <= WSTRB;
         end
         if (w_wr_go) begin
            r_bvalid <= 1'b1;
            r_bresp  <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
         end else if (r_bvalid && BREADY) begin
            r_bvalid  <= 1'b0;
            r_aw_full <= 1'b0;
            r_w_full  <= 1'b0;
         end
      end
   end

   // read channel: response captured from live register contents
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
         r_rresp  <= RESP_OKAY;
      end else begin
         if (ARVALID && ARREADY) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_data;
            r_rresp  <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
         end else if (r_rvalid && RREADY) begin
            r_rvalid <= 1'b0;
         end
      end
   end

   // writable registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_en   <= 1'b1;
         r_scratch <= '0;
      end else if (w_wr_go) begin
         if (r_aw_addr == ADDR_CTRL && r_w_strb[0]) begin
            r_rx_en <= r_w_data[0];
         end
         if (r_aw_addr == ADDR_SCRATCH) begin
            r_scratch <= (r_scratch & ~w_wmask) | (r_w_data & w_wmask);
         end
      end
   end

   // stream statistics; a same-edge clear takes priority over a beat
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pkt_cnt  <= '0;
         r_byte_cnt <= '0;
         r_last_lo  <= '0;
         r_last_hi  <= '0;
      end else if (w_cnt_clr) begin
         r_pkt_cnt  <= '0;
         r_byte_cnt <= '0;
         r_last_lo  <= '0;
         r_last_hi  <= '0;
      end else if (w_beat) begin
         r_byte_cnt <= r_byte_cnt + w_keep_cnt;
         if (tlast) begin
            r_pkt_cnt <= r_pkt_cnt + 32'd1;
         end
         r_last_lo <= tdata[31:0];
         r_last_hi <= w_tdata_hi;
      end
   end

endmodule

// File: tb/tb_dataplane_core.sv
// tb_dataplane_core
//    Directed-vector bench for dataplane_core (DATA_WIDTH = 64).
//    Inputs are driven on the falling clock edge and outputs observed there,
//    half a cycle away from the active rising edge.
module tb_dataplane_core;

   localparam int DW = 64;

   logic          clk;
   logic          rst_n;
   logic [31:0]   AWADDR;
   logic [2:0]    AWPROT;
   logic          AWVALID;
   logic          AWREADY;
   logic [31:0]   WDATA;
   logic [3:0]    WSTRB;
   logic          WVALID;
   logic          WREADY;
   logic          BVALID;
   logic          BREADY;
   logic [1:0]    BRESP;
   logic [31:0]   ARADDR;
   logic [2:0]    ARPROT;
   logic          ARVALID;
   logic          ARREADY;
   logic          RVALID;
   logic          RREADY;
   logic [31:0]   RDATA;
   logic [1:0]    RRESP;
   logic          tvalid;
   logic [DW-1:0] tdata;
   logic [DW/8-1:0] tkeep;
   logic          tlast;
   logic          tready;

   int n_vec;
   int n_miscmp;

   logic [31:0] rd_data;
   logic [1:0]  rd_resp;
   logic [1:0]  wr_resp;

   dataplane_core #(.DATA_WIDTH(DW)) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .AWADDR  (AWADDR),
      .AWPROT  (AWPROT),
      .AWVALID (AWVALID),
      .AWREADY (AWREADY),
      .WDATA   (WDATA),
      .WSTRB   (WSTRB),
      .WVALID  (WVALID),
      .WREADY  (WREADY),
      .BVALID  (BVALID),
      .BREADY  (BREADY),
      .BRESP   (BRESP),
      .ARADDR  (ARADDR),
      .ARPROT  (ARPROT),
      .ARVALID (ARVALID),
      .ARREADY (ARREADY),
      .RVALID  (RVALID),
      .RREADY  (RREADY),
      .RDATA   (RDATA),
      .RRESP   (RRESP),
      .tvalid  (tvalid),
      .tdata   (tdata),
      .tkeep   (tkeep),
      .tlast   (tlast),
      .tready  (tready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miscmp++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp);
      int unsigned n;
      logic a_hs;
      logic w_hs;
      @(negedge clk);
      AWADDR  = addr;
      WDATA   = data;
      WSTRB   = strb;
      AWVALID = 1'b1;
      WVALID  = 1'b1;
      BREADY  = 1'b1;
      n = 0;
      while ((AWVALID || WVALID) && n < 20) begin
         a_hs = AWVALID && AWREADY;
         w_hs = WVALID && WREADY;
         @(negedge clk);
         if (a_hs) AWVALID = 1'b0;
         if (w_hs) WVALID  = 1'b0;
         n++;
      end
      if (n >= 20) check_vec("wr_hs_timeout", 32'(AWVALID || WVALID), 32'd0);
      n = 0;
      while (!BVALID && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) check_vec("wr_b_timeout", 32'(BVALID), 32'd1);
      resp = BRESP;
      AWVALID = 1'b0;
      WVALID  = 1'b0;
   endtask

   task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                           output logic [1:0] resp);
      int unsigned n;
      @(negedge clk);
      ARADDR  = addr;
      ARVALID = 1'b1;
      RREADY  = 1'b1;
      n = 0;
      while (!ARREADY && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) check_vec("rd_ar_timeout", 32'(ARREADY), 32'd1);
      @(negedge clk);
      ARVALID = 1'b0;
      n = 0;
      while (!RVALID && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) check_vec("rd_r_timeout", 32'(RVALID), 32'd1);
      data = RDATA;
      resp = RRESP;
   endtask

   task automatic rd_chk(input string tag, input logic [31:0] addr,
                         input logic [31:0] exp, input logic [1:0] exp_resp);
      axi_read(addr, rd_data, rd_resp);
      check_vec(tag, rd_data, exp);
      check_vec({tag, "_resp"}, 32'(rd_resp), 32'(exp_resp));
   endtask

   task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
      @(negedge clk);
      tvalid = 1'b1;
      tdata  = d;
      tkeep  = k;
      tlast  = l;
      @(negedge clk);
      tvalid = 1'b0;
      tlast  = 1'b0;
   endtask

   initial begin
      n_vec    = 0;
      n_miscmp = 0;
      rst_n   = 1'b0;
      AWADDR  = '0;
      AWPROT  = '0;
      AWVALID = 1'b0;
      WDATA   = '0;
      WSTRB   = '0;
      WVALID  = 1'b0;
      BREADY  = 1'b1;
      ARADDR  = '0;
      ARPROT  = '0;
      ARVALID = 1'b0;
      RREADY  = 1'b1;
      tvalid  = 1'b0;
      tdata   = '0;
      tkeep   = '0;
      tlast   = 1'b0;

      // reset state
      repeat (3) @(negedge clk);
      check_vec("rst_awready", 32'(AWREADY), 32'd0);
      check_vec("rst_wready",  32'(WREADY),  32'd0);
      check_vec("rst_arready", 32'(ARREADY), 32'd0);
      check_vec("rst_bvalid",  32'(BVALID),  32'd0);
      check_vec("rst_rvalid",  32'(RVALID),  32'd0);
      check_vec("rst_rdata",   RDATA,        32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check_vec("rel_tready",  32'(tready),  32'd1);
      check_vec("rel_awready", 32'(AWREADY), 32'd1);
      check_vec("rel_arready", 32'(ARREADY), 32'd1);

      rd_chk("rst_ctrl",    32'h00, 32'h0000_0001, 2'b00);
      rd_chk("rst_scratch", 32'h04, 32'h0000_0000, 2'b00);
      rd_chk("rst_version", 32'h18, 32'h0001_0000, 2'b00);
      rd_chk("rst_pkt",     32'h08, 32'h0000_0000, 2'b00);

      // scratch full write then byte-strobed write
      axi_write(32'h04, 32'hDEAD_BEEF, 4'hF, wr_resp);
      check_vec("scr_bresp", 32'(wr_resp), 32'd0);
      rd_chk("scr_full", 32'h04, 32'hDEAD_BEEF, 2'b00);
      axi_write(32'h04, 32'h0000_0012, 4'h1, wr_resp);
      check_vec("scr_strb_bresp", 32'(wr_resp), 32'd0);
      rd_chk("scr_strb", 32'h04, 32'hDEAD_BE12, 2'b00);

      // AW two cycles ahead of W, BREADY held low for 3 cycles
      @(negedge clk);
      BREADY  = 1'b0;
      AWADDR  = 32'h04;
      AWVALID = 1'b1;
      check_vec("awfirst_awready", 32'(AWREADY), 32'd1);
      @(negedge clk);
      AWVALID = 1'b0;
      check_vec("awfirst_awready_held", 32'(AWREADY), 32'd0);
      @(negedge clk);
      WDATA  = 32'h55AA_55AA;
      WSTRB  = 4'hF;
      WVALID = 1'b1;
      check_vec("awfirst_wready", 32'(WREADY), 32'd1);
      check_vec("awfirst_bvalid_early", 32'(BVALID), 32'd0);
      @(negedge clk);
      WVALID = 1'b0;
      check_vec("awfirst_bvalid_n0", 32'(BVALID), 32'd0);
      @(negedge clk);
      check_vec("awfirst_bvalid_n1", 32'(BVALID), 32'd1);
      check_vec("awfirst_bresp", 32'(BRESP), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_vec("awfirst_bvalid_hold", 32'(BVALID), 32'd1);
      end
      BREADY = 1'b1;
      @(negedge clk);
      check_vec("awfirst_bvalid_clr", 32'(BVALID), 32'd0);
      rd_chk("awfirst_data", 32'h04, 32'h55AA_55AA, 2'b00);

      // W two cycles ahead of AW
      @(negedge clk);
      WDATA  = 32'h0F0F_1234;
      WSTRB  = 4'hF;
      WVALID = 1'b1;
      check_vec("wfirst_wready", 32'(WREADY), 32'd1);
      @(negedge clk);
      WVALID = 1'b0;
      @(negedge clk);
      AWADDR  = 32'h04;
      AWVALID = 1'b1;
      check_vec("wfirst_awready", 32'(AWREADY), 32'd1);
      @(negedge clk);
      AWVALID = 1'b0;
      check_vec("wfirst_bvalid_n0", 32'(BVALID), 32'd0);
      @(negedge clk);
      check_vec("wfirst_bvalid_n1", 32'(BVALID), 32'd1);
      rd_chk("wfirst_data", 32'h04, 32'h0F0F_1234, 2'b00);

      // unmapped address and read-only write
      axi_write(32'h40, 32'h1234_5678, 4'hF, wr_resp);
      check_vec("bad_bresp", 32'(wr_resp), 32'd2);
      rd_chk("bad_rd", 32'h40, 32'h0000_0000, 2'b10);
      axi_write(32'h18, 32'h0000_0000, 4'hF, wr_resp);
      check_vec("ro_bresp", 32'(wr_resp), 32'd0);
      rd_chk("ro_version", 32'h18, 32'h0001_0000, 2'b00);

      // 3-beat packet: 8 + 8 + 4 bytes
      send_beat(64'h0102_0304_0506_0708, 8'hFF, 1'b0);
      send_beat(64'h090A_0B0C_0D0E_0F10, 8'hFF, 1'b0);
      send_beat(64'h1122_3344_5566_7788, 8'h0F, 1'b1);
      rd_chk("pkt_cnt",  32'h08, 32'd1,          2'b00);
      rd_chk("byte_cnt", 32'h0C, 32'd20,         2'b00);
      rd_chk("last_lo",  32'h10, 32'h5566_7788,  2'b00);
      rd_chk("last_hi",  32'h14, 32'h1122_3344,  2'b00);

      // receive disabled: beat ignored
      axi_write(32'h00, 32'h0000_0000, 4'hF, wr_resp);
      @(negedge clk);
      check_vec("dis_tready", 32'(tready), 32'd0);
      send_beat(64'hCAFE_F00D_DEAD_0001, 8'hFF, 1'b1);
      rd_chk("dis_ctrl",    32'h00, 32'd0,         2'b00);
      rd_chk("dis_pkt",     32'h08, 32'd1,         2'b00);
      rd_chk("dis_byte",    32'h0C, 32'd20,        2'b00);
      rd_chk("dis_last_lo", 32'h10, 32'h5566_7788, 2'b00);

      // re-enable with counter clear
      axi_write(32'h00, 32'h0000_0003, 4'hF, wr_resp);
      @(negedge clk);
      check_vec("clr_tready", 32'(tready), 32'd1);
      rd_chk("clr_ctrl",    32'h00, 32'd1, 2'b00);
      rd_chk("clr_pkt",     32'h08, 32'd0, 2'b00);
      rd_chk("clr_byte",    32'h0C, 32'd0, 2'b00);
      rd_chk("clr_last_lo", 32'h10, 32'd0, 2'b00);
      rd_chk("clr_last_hi", 32'h14, 32'd0, 2'b00);

      // sparse keep (2 bytes) then empty keep closing the packet
      send_beat(64'h0000_0000_0000_00AB, 8'h81, 1'b0);
      send_beat(64'h0000_0001_0000_0002, 8'h00, 1'b1);
      rd_chk("sparse_pkt",     32'h08, 32'd1, 2'b00);
      rd_chk("sparse_byte",    32'h0C, 32'd2, 2'b00);
      rd_chk("sparse_last_lo", 32'h10, 32'd2, 2'b00);
      rd_chk("sparse_last_hi", 32'h14, 32'd1, 2'b00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
      $finish;
   end

endmodule
